// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - req/gnt/rvalid data-bus between the load/store unit and memory
interface load_store_unit_if;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   // Load/store unit side: issues requests, consumes grant and response
   modport master (
      output req, we, be, addr, wdata,
      input  gnt, rvalid, rdata
   );

   // Memory side: accepts requests, returns grant and response
   modport slave (
      input  req, we, be, addr, wdata,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - one-at-a-time RV32I load/store engine on a req/gnt/rvalid data bus
module load_store_unit #(
   parameter int MAX_WAIT = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               req_valid_i,
   input  logic               req_we_i,
   input  logic [2:0]         req_funct3_i,
   input  logic [31:0]        req_addr_i,
   input  logic [31:0]        req_wdata_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [31:0]        load_data_o,
   output logic               misaligned_o,
   output logic               fault_o,
   load_store_unit_if.master  mem
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           we_q, we_d;
   logic [2:0]     f3_q, f3_d;
   logic [1:0]     off_q, off_d;
   logic [31:0]    addr_q, addr_d;
   logic [3:0]     be_q, be_d;
   logic [31:0]    wdata_q, wdata_d;
   logic [31:0]    load_q, load_d;
   logic           mis_q, mis_d;
   logic           fault_q, fault_d;

   // Request decode: illegal funct3 (including unsigned stores) and size misalignment
   logic           req_illegal, req_mis, req_err, timeout;
   logic [3:0]     req_be;
   logic [31:0]    req_wrep;
   logic [31:0]    rshift;
   logic [31:0]    fmt_load;

   assign req_illegal = (req_funct3_i == 3'b011) || (req_funct3_i == 3'b110) ||
                        (req_funct3_i == 3'b111) || (req_we_i && req_funct3_i[2]);
   assign req_mis     = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                        ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
   assign req_err     = req_illegal || req_mis;
   assign timeout     = (cnt_q == CW'(MAX_WAIT - 1));

   // Byte enables and replicated write data derived from access size and offset
   always_comb begin
      req_be   = 4'b1111;
      req_wrep = req_wdata_i;
      case (req_funct3_i[1:0])
         2'b00: begin
            req_be   = 4'b0001 << req_addr_i[1:0];
            req_wrep = {4{req_wdata_i[7:0]}};
         end
         2'b01: begin
            req_be   = req_addr_i[1] ? 4'b1100 : 4'b0011;
            req_wrep = {2{req_wdata_i[15:0]}};
         end
         default: begin
            req_be   = 4'b1111;
            req_wrep = req_wdata_i;
         end
      endcase
   end

   // Read data alignment: shift the addressed lane down, then sign/zero extend
   always_comb begin
      rshift   = mem.rdata >> {off_q, 3'b000};
      fmt_load = mem.rdata;
      case (f3_q[1:0])
         2'b00:   fmt_load = f3_q[2] ? {24'd0, rshift[7:0]}  : {{24{rshift[7]}}, rshift[7:0]};
         2'b01:   fmt_load = f3_q[2] ? {16'd0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
         default: fmt_load = mem.rdata;
      endcase
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic; a timeout in REQ wins over a same-cycle grant so the request drops cleanly
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (req_valid_i) state_d = req_err ? S_RESP : S_REQ;
         S_REQ: begin
            if (timeout)        state_d = S_RESP;
            else if (mem.gnt)   state_d = S_WAIT;
         end
         S_WAIT: if (mem.rvalid || timeout) state_d = S_RESP;
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs: bus fields are only driven while the request is outstanding
   always_comb begin
      busy_o       = rst_ni && (((state_q == S_IDLE) && req_valid_i) ||
                                (state_q == S_REQ) || (state_q == S_WAIT));
      done_o       = (state_q == S_RESP);
      misaligned_o = (state_q == S_RESP) && mis_q;
      fault_o      = (state_q == S_RESP) && fault_q;
      load_data_o  = load_q;
      mem.req      = (state_q == S_REQ);
      mem.we       = (state_q == S_REQ) && we_q;
      mem.be       = (state_q == S_REQ) ? be_q    : 4'd0;
      mem.addr     = (state_q == S_REQ) ? addr_q  : 32'd0;
      mem.wdata    = (state_q == S_REQ) ? wdata_q : 32'd0;
   end

   // Datapath next-state: capture in IDLE, count in REQ/WAIT, settle result on the way to RESP
   always_comb begin
      cnt_d   = cnt_q;
      we_d    = we_q;
      f3_d    = f3_q;
      off_d   = off_q;
      addr_d  = addr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      load_d  = load_q;
      mis_d   = mis_q;
      fault_d = fault_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               mis_d   = req_mis;
               fault_d = req_illegal;
               if (req_err) begin
                  load_d = 32'd0;
               end else begin
                  cnt_d   = '0;
                  we_d    = req_we_i;
                  f3_d    = req_funct3_i;
                  off_d   = req_addr_i[1:0];
                  addr_d  = {req_addr_i[31:2], 2'b00};
                  be_d    = req_be;
                  wdata_d = req_wrep;
               end
            end
         end
         S_REQ: begin
            cnt_d = cnt_q + CW'(1);
            if (timeout) begin
               fault_d = 1'b1;
               load_d  = 32'd0;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (mem.rvalid) begin
               load_d = we_q ? 32'd0 : fmt_load;
            end else if (timeout) begin
               fault_d = 1'b1;
               load_d  = 32'd0;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         off_q   <= 2'd0;
         addr_q  <= 32'd0;
         be_q    <= 4'd0;
         wdata_q <= 32'd0;
         load_q  <= 32'd0;
         mis_q   <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         addr_q  <= addr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         load_q  <= load_d;
         mis_q   <= mis_d;
         fault_q <= fault_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        busy, done, misaligned, fault;
   logic [31:0] load_data;
   int          n_checks = 0;
   int          n_err = 0;

   load_store_unit_if mif ();

   load_store_unit #(.MAX_WAIT(8)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_valid_i  (req_valid),
      .req_we_i     (req_we),
      .req_funct3_i (req_funct3),
      .req_addr_i   (req_addr),
      .req_wdata_i  (req_wdata),
      .busy_o       (busy),
      .done_o       (done),
      .load_data_o  (load_data),
      .misaligned_o (misaligned),
      .fault_o      (fault),
      .mem          (mif.master)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accepted access: gnt after gnt_dly idle REQ cycles, rvalid rv_dly cycles after gnt
   task automatic run_access(input string tag, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input int gnt_dly, input int rv_dly, input logic [31:0] rdata,
                             input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                             input logic [31:0] exp_load);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
      #1;
      chk({tag, " busy@accept"}, 32'(busy), 32'd1);
      chk({tag, " req@accept"}, 32'(mif.req), 32'd0);
      tick();
      req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555; req_we = ~we; req_funct3 = 3'b010;
      for (int i = 0; i <= gnt_dly; i++) begin
         mif.gnt = (i == gnt_dly); mif.rvalid = 1'b1; mif.rdata = 32'hBAD0_BAD0;
         #1;
         chk({tag, " req"}, 32'(mif.req), 32'd1);
         chk({tag, " addr"}, mif.addr, {addr[31:2], 2'b00});
         chk({tag, " be"}, 32'(mif.be), 32'(exp_be));
         chk({tag, " we"}, 32'(mif.we), 32'(we));
         chk({tag, " wdata"}, mif.wdata, exp_wdata);
         chk({tag, " busy@req"}, 32'(busy), 32'd1);
         chk({tag, " done@req"}, 32'(done), 32'd0);
         tick();
      end
      mif.gnt = 1'b0;
      for (int j = 1; j <= rv_dly; j++) begin
         mif.rvalid = (j == rv_dly);
         mif.rdata  = (j == rv_dly) ? rdata : 32'hBAD0_BAD0;
         #1;
         chk({tag, " req@wait"}, 32'(mif.req), 32'd0);
         chk({tag, " busy@wait"}, 32'(busy), 32'd1);
         chk({tag, " done@wait"}, 32'(done), 32'd0);
         tick();
      end
      mif.rvalid = 1'b0; mif.rdata = 32'h0;
      req_valid = 1'b0;
      #1;
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " load_data"}, load_data, exp_load);
      chk({tag, " misaligned"}, 32'(misaligned), 32'd0);
      chk({tag, " fault"}, 32'(fault), 32'd0);
      chk({tag, " busy@resp"}, 32'(busy), 32'd0);
      tick();
      chk({tag, " done pulse"}, 32'(done), 32'd0);
      chk({tag, " load hold"}, load_data, exp_load);
   endtask

   // Rejected access: completes the cycle after acceptance with no bus activity
   task automatic run_err(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic exp_mis, input logic exp_fault);
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = 32'h1234_5678;
      #1;
      chk({tag, " busy@accept"}, 32'(busy), 32'd1);
      chk({tag, " req@accept"}, 32'(mif.req), 32'd0);
      tick();
      req_valid = 1'b0;
      #1;
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " misaligned"}, 32'(misaligned), 32'(exp_mis));
      chk({tag, " fault"}, 32'(fault), 32'(exp_fault));
      chk({tag, " load_data"}, load_data, 32'd0);
      chk({tag, " req@resp"}, 32'(mif.req), 32'd0);
      tick();
      chk({tag, " done pulse"}, 32'(done), 32'd0);
      chk({tag, " flags clear"}, 32'({misaligned, fault}), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed time limit reached expected bench to finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0;
      mif.gnt = 1'b0; mif.rvalid = 1'b0; mif.rdata = 32'd0;
      tick(); tick();
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset load_data", load_data, 32'd0);
      chk("reset req", 32'(mif.req), 32'd0);
      chk("reset flags", 32'({misaligned, fault}), 32'd0);
      rst_n = 1'b1;
      tick();

      run_access("LB", 1'b0, 3'b000, 32'h0000_1003, 32'h0, 0, 1, 32'h80FF_1234,
                 4'b1000, 32'h0, 32'hFFFF_FF80);
      run_access("LBU", 1'b0, 3'b100, 32'h0000_1003, 32'h0, 0, 1, 32'h80FF_1234,
                 4'b1000, 32'h0, 32'h0000_0080);
      run_access("SH", 1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 0, 1, 32'hDEAD_BEEF,
                 4'b1100, 32'hBEEF_BEEF, 32'h0);
      run_access("SB", 1'b1, 3'b000, 32'h0000_3001, 32'h1234_56A5, 1, 1, 32'hDEAD_BEEF,
                 4'b0010, 32'hA5A5_A5A5, 32'h0);
      run_access("LH slow", 1'b0, 3'b001, 32'h0000_0010, 32'h0, 4, 2, 32'h0000_F00D,
                 4'b0011, 32'h0, 32'hFFFF_F00D);
      run_access("LHU", 1'b0, 3'b101, 32'h0000_0012, 32'h0, 0, 1, 32'h8001_1234,
                 4'b1100, 32'h0, 32'h0000_8001);

      // Reset while waiting for the response
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0100;
      tick();
      req_valid = 1'b0; mif.gnt = 1'b1;
      #1;
      chk("RST req before", 32'(mif.req), 32'd1);
      tick();
      mif.gnt = 1'b0;
      #1;
      chk("RST busy in wait", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("RST busy", 32'(busy), 32'd0);
      chk("RST done", 32'(done), 32'd0);
      chk("RST load_data", load_data, 32'd0);
      chk("RST bus", 32'({mif.req, mif.we, mif.be}), 32'd0);
      chk("RST addr", mif.addr, 32'd0);
      tick();
      rst_n = 1'b1; mif.rvalid = 1'b1; mif.rdata = 32'hCAFE_CAFE;
      #1;
      chk("RST late rvalid done", 32'(done), 32'd0);
      tick();
      mif.rvalid = 1'b0;
      #1;
      chk("RST late rvalid done2", 32'(done), 32'd0);
      chk("RST late rvalid busy", 32'(busy), 32'd0);
      run_access("LW after reset", 1'b0, 3'b010, 32'h0000_0104, 32'hCAFE_F00D, 0, 1,
                 32'h1234_5678, 4'b1111, 32'hCAFE_F00D, 32'h1234_5678);

      run_err("LW misaligned", 1'b0, 3'b010, 32'h0000_0006, 1'b1, 1'b0);
      run_err("LH misaligned", 1'b0, 3'b001, 32'h0000_0011, 1'b1, 1'b0);
      run_err("funct3 011", 1'b0, 3'b011, 32'h0000_0020, 1'b0, 1'b1);
      run_err("store BU", 1'b1, 3'b100, 32'h0000_0020, 1'b0, 1'b1);

      // Load that sets a nonzero result so the timeout clearing it is visible
      run_access("LW pre-timeout", 1'b0, 3'b010, 32'h0000_0200, 32'h0, 0, 1,
                 32'h0BAD_F00D, 4'b1111, 32'h0, 32'h0BAD_F00D);

      // Timeout: grant never arrives, MAX_WAIT=8 -> done at T+9
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0040;
      tick();
      req_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         #1;
         chk("TO req held", 32'(mif.req), 32'd1);
         chk("TO no done", 32'(done), 32'd0);
         tick();
      end
      #1;
      chk("TO done", 32'(done), 32'd1);
      chk("TO fault", 32'(fault), 32'd1);
      chk("TO misaligned", 32'(misaligned), 32'd0);
      chk("TO req dropped", 32'(mif.req), 32'd0);
      chk("TO load_data", load_data, 32'd0);
      tick();
      mif.rvalid = 1'b1; mif.rdata = 32'h7777_7777;
      #1;
      chk("TO late rvalid done", 32'(done), 32'd0);
      tick();
      mif.rvalid = 1'b0;
      #1;
      chk("TO late rvalid done2", 32'(done), 32'd0);
      chk("TO late rvalid load", load_data, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
